arbitro_rr: RTL and testbench
=============================

ARBITRO_RR -- requirements
Module: arbitro_rr

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 fifo_out  input  12  head word of the granted input FIFO, valid the cycle after that FIFO's pop; bits [11:10] = destination output FIFO index.
REQ-004 empty  input  4  empty flag per input FIFO P0..P3, bit i = FIFO i.
REQ-005 almost_full  input  4  almost-full flag per output FIFO 0..3.
REQ-006 pop  output  4  one-hot read strobe to input FIFOs; at most one bit set per cycle.
REQ-007 push  output  4  one-hot write strobe to output FIFOs, registered.
REQ-008 data_out  output  12  word written to output FIFOs, registered, valid when push != 0.
REQ-009 grant  output  2  index of the input FIFO currently served, registered.
REQ-010 busy  output  1  high while state = SERVE.

Function
REQ-011 State machine with two states: IDLE and SERVE; encoding is free.
REQ-012 IDLE: if empty != 4'b1111, grant <= first index i with empty[i]=0, searching round-robin from (grant+1) mod 4 upward with wrap; next state SERVE. If empty = 4'b1111, stay IDLE and hold grant.
REQ-013 SERVE: pop[grant] = 1 combinationally iff empty[grant]=0 and almost_full = 4'b0000; all other pop bits 0.
REQ-014 SERVE: grant holds while empty[grant]=0; when empty[grant]=1, no pop that cycle, next state IDLE (one bubble cycle before the next FIFO is served).
REQ-015 Any almost_full bit set stalls all pops (destination unknown before read); grant and state hold during the stall.
REQ-016 Read-valid flag rd_vld <= (pop != 0); when rd_vld=1, at the next edge: data_out <= fifo_out, push <= one-hot(fifo_out[11:10]); otherwise push <= 4'b0000 and data_out holds.
REQ-017 Latency: pop in cycle N -> push and data_out visible in cycle N+2; throughput is one word per cycle while unstalled.
REQ-018 Output FIFOs assert almost_full with at least 2 free entries; in-flight words are always pushed, even if almost_full rises after their pop.
REQ-019 An empty change in the same cycle as a pop decision uses the current-cycle value of empty; no pop is issued to an empty FIFO.
REQ-020 Round-robin wrap: grant 3 -> search order 0,1,2,3; grant 3 with only FIFO 3 non-empty re-grants 3.
REQ-021 pop is zero in IDLE and at all times while reset=1.

Reset
REQ-022 On reset=1: state IDLE, grant 2'd3 (first IDLE search starts at P0), rd_vld 0, push 4'b0000, data_out 12'h000, busy 0.
REQ-023 Reset mid-operation discards any in-flight word (no push after reset release); operation resumes from IDLE on the first edge after reset falls.

Verification
REQ-024 Reset 2 cycles, empty=4'b0100, almost_full=0 -> grant=0, busy=1 on second edge after release; pop=4'b0001 each cycle; word 12'b001010010110 yields push=4'b0001, data_out=12'h296 two cycles after first pop.
REQ-025 empty[0] rises while serving P0 -> one IDLE bubble cycle with pop=0, then grant=1, pop=4'b0010; P2 skipped while empty[2]=1.
REQ-026 Word 12'b101011110000 from P1 -> push=4'b0100, data_out=12'hAF0; word 12'b111100101001 -> push=4'b1000, data_out=12'hF29.
REQ-027 almost_full[2] set while pops active -> pop=0 from that cycle; exactly the 2 in-flight words still pushed; pops resume the cycle after almost_full returns to 0.
REQ-028 Assert reset while push active and rd_vld=1 -> push=0, data_out=0 immediately (asynchronous); no stray push after release.
REQ-029 grant=3, empty=4'b0110 after P3 drains -> next grant 0, then after P0 drains, grant 3; pop always one-hot or zero (assertion checked every cycle).

Source files
------------

// File: rtl/arbitro_rr_if.sv
// arbitro_rr_if -- bus between the round-robin arbiter and its FIFOs.
//   fifo_out     head word of the granted input FIFO (valid cycle after pop)
//   empty        per-input-FIFO empty flags
//   almost_full  per-output-FIFO almost-full flags
//   pop          one-hot read strobe to the input FIFOs
//   push         one-hot write strobe to the output FIFOs
//   data_out     word written to the output FIFOs
//   grant        index of the input FIFO being served
//   busy         arbiter is serving a FIFO
// master: arbiter side.  slave: FIFO / environment side.
interface arbitro_rr_if #(
   parameter int N = 4,
   parameter int W = 12
);
   localparam int GW = $clog2(N);

   logic [W-1:0]  fifo_out;
   logic [N-1:0]  empty;
   logic [N-1:0]  almost_full;
   logic [N-1:0]  pop;
   logic [N-1:0]  push;
   logic [W-1:0]  data_out;
   logic [GW-1:0] grant;
   logic          busy;

   modport master (
      input  fifo_out, empty, almost_full,
      output pop, push, data_out, grant, busy
   );

   modport slave (
      output fifo_out, empty, almost_full,
      input  pop, push, data_out, grant, busy
   );
endinterface

// File: rtl/arbitro_rr.sv
// arbitro_rr -- round-robin arbiter moving words from N input FIFOs to
// N output FIFOs. The destination of each word is carried in its top
// GW bits.
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    arbitro_rr_if.master (see interface header for signal list)
// A pop in cycle N appears as push/data_out in cycle N+2: the FIFO head
// arrives one cycle after the pop, and the push is registered.
module arbitro_rr #(
   parameter int N = 4,
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         reset,
   arbitro_rr_if.master bus
);
   localparam int GW = $clog2(N);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t        state, state_nx;
   logic [GW-1:0] grant, grant_nx;
   logic [GW-1:0] rr_idx, idx;
   logic          rr_hit;
   logic          stall;
   logic [N-1:0]  pop_c;
   logic [N-1:0]  push_d, push_q;
   logic [W-1:0]  data_q;
   logic          rd_vld;

   // The destination is unknown until the word is read, so any
   // almost-full output blocks every pop.
   assign stall = |bus.almost_full;

   // Round-robin search starting at grant+1 with wrap. Scanning from the
   // largest offset down lets the smallest offset win; offset N is grant
   // itself, so a lone non-empty current FIFO is re-granted.
   always_comb begin
      rr_hit = 1'b0;
      rr_idx = grant;
      idx    = '0;
      for (int k = N; k >= 1; k--) begin
         idx = grant + k[GW-1:0];
         if (!bus.empty[idx]) begin
            rr_hit = 1'b1;
            rr_idx = idx;
         end
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant;
      pop_c    = '0;
      case (state)
         IDLE: begin
            if (rr_hit) begin
               grant_nx = rr_idx;
               state_nx = SERVE;
            end
         end
         SERVE: begin
            // Stall holds both grant and state.
            if (!stall) begin
               if (bus.empty[grant]) state_nx = IDLE;
               else                  pop_c[grant] = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Destination decode of the word arriving from the FIFO this cycle.
   always_comb begin
      push_d = '0;
      push_d[bus.fifo_out[W-1 -: GW]] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         grant  <= GW'(N-1);   // first search starts at FIFO 0
         rd_vld <= 1'b0;
         push_q <= '0;
         data_q <= '0;
      end else begin
         state  <= state_nx;
         grant  <= grant_nx;
         rd_vld <= |pop_c;
         if (rd_vld) begin
            push_q <= push_d;
            data_q <= bus.fifo_out;
         end else begin
            push_q <= '0;
         end
      end
   end

   assign bus.pop      = pop_c;
   assign bus.push     = push_q;
   assign bus.data_out = data_q;
   assign bus.grant    = grant;
   assign bus.busy     = (state == SERVE);
endmodule

// File: tb/tb_arbitro_rr.sv
// tb_arbitro_rr -- directed bench for arbitro_rr. Input FIFOs are modelled
// as small memories with read/write pointers; the bench loads words and
// checks pop/push/data_out/grant/busy cycle by cycle against hand-derived
// timelines.
module tb_arbitro_rr;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   arbitro_rr_if bus ();

   arbitro_rr dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [11:0] mem [4][64];
   logic [5:0]  wptr [4] = '{default: 6'd0};
   logic [5:0]  rptr [4] = '{default: 6'd0};
   logic [3:0]  force_e = 4'b0000;
   logic [3:0]  af = 4'b0000;
   logic        flush = 1'b0;

   assign bus.almost_full = af;

   always_comb begin
      bus.empty = 4'b0000;
      for (int i = 0; i < 4; i++) bus.empty[i] = force_e[i] | (rptr[i] == wptr[i]);
   end

   // FIFO read side: head word appears the cycle after the pop.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (flush) begin
            rptr[i] <= wptr[i];
         end else if (bus.pop[i]) begin
            bus.fifo_out <= mem[i][rptr[i]];
            rptr[i]      <= rptr[i] + 6'd1;
         end
      end
   end

   // Every cycle: pop one-hot or zero, and zero while reset is high.
   always @(negedge clk) begin
      checks++;
      if (!$onehot0(bus.pop) || (reset && bus.pop != 4'b0000)) begin
         errors++;
         $display("FAIL pop_onehot t=%0t got=%b reset=%b exp=onehot0/zero-in-reset", $time, bus.pop, reset);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t got=running exp=finished", $time);
      $fatal(1, "timeout");
   end

   task automatic load(input int p, input logic [11:0] w);
      mem[p][wptr[p]] = w;
      wptr[p] = wptr[p] + 6'd1;
   endtask

   task automatic step;
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset;
      step; step;
      // Load while reset is held: empty becomes 4'b0100.
      load(0, 12'h296); load(0, 12'h123); load(0, 12'h6AB);
      load(1, 12'hAF0); load(1, 12'hF29);
      load(3, 12'h8C5);
      #1;
      checks++; if (bus.pop !== 4'b0000) begin errors++; $display("FAIL rst_pop got=%b exp=0000", bus.pop); end
      checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL rst_push got=%b exp=0000", bus.push); end
      checks++; if (bus.data_out !== 12'h000) begin errors++; $display("FAIL rst_data got=%h exp=000", bus.data_out); end
      checks++; if (bus.grant !== 2'd3) begin errors++; $display("FAIL rst_grant got=%0d exp=3", bus.grant); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      reset = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.pop !== 4'b0000) begin errors++; $display("FAIL rel_idle got busy=%b pop=%b exp busy=0 pop=0000", bus.busy, bus.pop); end
   endtask

   task automatic test_basic;
      step; // c1
      checks++; if (bus.busy !== 1'b1 || bus.pop !== 4'b0001) begin errors++; $display("FAIL basic_c1 got busy=%b pop=%b exp busy=1 pop=0001", bus.busy, bus.pop); end
      step; // c2
      checks++; if (bus.grant !== 2'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_grant got grant=%0d busy=%b exp grant=0 busy=1", bus.grant, bus.busy); end
      checks++; if (bus.pop !== 4'b0001) begin errors++; $display("FAIL basic_pop2 got=%b exp=0001", bus.pop); end
      step; // c3
      checks++; if (bus.push !== 4'b0001 || bus.data_out !== 12'h296) begin errors++; $display("FAIL basic_w0 got push=%b data=%h exp push=0001 data=296", bus.push, bus.data_out); end
      step; // c4
      checks++; if (bus.push !== 4'b0001 || bus.data_out !== 12'h123) begin errors++; $display("FAIL basic_w1 got push=%b data=%h exp push=0001 data=123", bus.push, bus.data_out); end
      checks++; if (bus.pop !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_drain got pop=%b busy=%b exp pop=0000 busy=1", bus.pop, bus.busy); end
   endtask

   task automatic test_switch;
      step; // c5: IDLE bubble
      checks++; if (bus.busy !== 1'b0 || bus.pop !== 4'b0000) begin errors++; $display("FAIL sw_bubble got busy=%b pop=%b exp busy=0 pop=0000", bus.busy, bus.pop); end
      checks++; if (bus.push !== 4'b0010 || bus.data_out !== 12'h6AB) begin errors++; $display("FAIL sw_w2 got push=%b data=%h exp push=0010 data=6AB", bus.push, bus.data_out); end
      step; // c6
      checks++; if (bus.grant !== 2'd1 || bus.pop !== 4'b0010) begin errors++; $display("FAIL sw_grant1 got grant=%0d pop=%b exp grant=1 pop=0010", bus.grant, bus.pop); end
      checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL sw_nopush got=%b exp=0000", bus.push); end
      step; // c7
      step; // c8
      checks++; if (bus.push !== 4'b0100 || bus.data_out !== 12'hAF0) begin errors++; $display("FAIL sw_af0 got push=%b data=%h exp push=0100 data=AF0", bus.push, bus.data_out); end
      step; // c9
      checks++; if (bus.push !== 4'b1000 || bus.data_out !== 12'hF29) begin errors++; $display("FAIL sw_f29 got push=%b data=%h exp push=1000 data=F29", bus.push, bus.data_out); end
      step; // c10: P2 skipped
      checks++; if (bus.grant !== 2'd3 || bus.pop !== 4'b1000) begin errors++; $display("FAIL sw_skip2 got grant=%0d pop=%b exp grant=3 pop=1000", bus.grant, bus.pop); end
      step; // c11
      step; // c12
      checks++; if (bus.push !== 4'b0100 || bus.data_out !== 12'h8C5) begin errors++; $display("FAIL sw_8c5 got push=%b data=%h exp push=0100 data=8C5", bus.push, bus.data_out); end
      step; // c13: all empty, hold
      checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'd3 || bus.push !== 4'b0000 || bus.data_out !== 12'h8C5) begin errors++; $display("FAIL sw_hold got busy=%b grant=%0d push=%b data=%h exp busy=0 grant=3 push=0000 data=8C5", bus.busy, bus.grant, bus.push, bus.data_out); end
   endtask

   task automatic test_stall;
      load(0, 12'hA01); load(0, 12'h402); load(0, 12'hC03);
      load(0, 12'h004); load(0, 12'h805); load(0, 12'h406);
      step; // s1
      checks++; if (bus.grant !== 2'd0 || bus.pop !== 4'b0001) begin errors++; $display("FAIL st_s1 got grant=%0d pop=%b exp grant=0 pop=0001", bus.grant, bus.pop); end
      step; // s2
      step; // s3
      af = 4'b0100;
      #1;
      checks++; if (bus.pop !== 4'b0000) begin errors++; $display("FAIL st_stop got=%b exp=0000", bus.pop); end
      checks++; if (bus.push !== 4'b0100 || bus.data_out !== 12'hA01) begin errors++; $display("FAIL st_fl0 got push=%b data=%h exp push=0100 data=A01", bus.push, bus.data_out); end
      step; // s4
      checks++; if (bus.push !== 4'b0010 || bus.data_out !== 12'h402 || bus.pop !== 4'b0000) begin errors++; $display("FAIL st_fl1 got push=%b data=%h pop=%b exp push=0010 data=402 pop=0000", bus.push, bus.data_out, bus.pop); end
      step; // s5
      checks++; if (bus.push !== 4'b0000 || bus.pop !== 4'b0000 || bus.busy !== 1'b1 || bus.grant !== 2'd0) begin errors++; $display("FAIL st_hold got push=%b pop=%b busy=%b grant=%0d exp push=0000 pop=0000 busy=1 grant=0", bus.push, bus.pop, bus.busy, bus.grant); end
      step; // s6
      af = 4'b0000;
      #1;
      checks++; if (bus.pop !== 4'b0001) begin errors++; $display("FAIL st_resume got=%b exp=0001", bus.pop); end
      step; // s7
      checks++; if (bus.push !== 4'b0000) begin errors++; $display("FAIL st_gap got=%b exp=0000", bus.push); end
      step; // s8
      checks++; if (bus.push !== 4'b1000 || bus.data_out !== 12'hC03) begin errors++; $display("FAIL st_c03 got push=%b data=%h exp push=1000 data=C03", bus.push, bus.data_out); end
      step; // s9
      checks++; if (bus.push !== 4'b0001 || bus.data_out !== 12'h004) begin errors++; $display("FAIL st_004 got push=%b data=%h exp push=0001 data=004", bus.push, bus.data_out); end
      step; // s10
      checks++; if (bus.push !== 4'b0100 || bus.data_out !== 12'h805 || bus.pop !== 4'b0000) begin errors++; $display("FAIL st_805 got push=%b data=%h pop=%b exp push=0100 data=805 pop=0000", bus.push, bus.data_out, bus.pop); end
      step; // s11
      checks++; if (bus.push !== 4'b0010 || bus.data_out !== 12'h406 || bus.busy !== 1'b0) begin errors++; $display("FAIL st_406 got push=%b data=%h busy=%b exp push=0010 data=406 busy=0", bus.push, bus.data_out, bus.busy); end
   endtask

   task automatic test_reset_mid;
      load(1, 12'h111); load(1, 12'h222); load(1, 12'h333); load(1, 12'h444);
      step; // r1
      checks++; if (bus.grant !== 2'd1 || bus.pop !== 4'b0010) begin errors++; $display("FAIL rm_grant got grant=%0d pop=%b exp grant=1 pop=0010", bus.grant, bus.pop); end
      step; // r2
      step; // r3
      checks++; if (bus.push !== 4'b0001 || bus.data_out !== 12'h111) begin errors++; $display("FAIL rm_push got push=%b data=%h exp push=0001 data=111", bus.push, bus.data_out); end
      force_e = 4'b1111;
      reset = 1'b1;
      #1;
      checks++; if (bus.push !== 4'b0000 || bus.data_out !== 12'h000) begin errors++; $display("FAIL rm_async got push=%b data=%h exp push=0000 data=000", bus.push, bus.data_out); end
      checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'd3 || bus.pop !== 4'b0000) begin errors++; $display("FAIL rm_state got busy=%b grant=%0d pop=%b exp busy=0 grant=3 pop=0000", bus.busy, bus.grant, bus.pop); end
      step; step;
      flush = 1'b1;
      step;
      flush = 1'b0;
      force_e = 4'b0000;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step;
         checks++; if (bus.push !== 4'b0000 || bus.busy !== 1'b0) begin errors++; $display("FAIL rm_stray%0d got push=%b busy=%b exp push=0000 busy=0", i, bus.push, bus.busy); end
      end
   endtask

   task automatic test_wrap;
      load(0, 12'h1AA);
      load(3, 12'hE55); load(3, 12'h366);
      step; // t1: search from 0 after reset
      checks++; if (bus.grant !== 2'd0 || bus.pop !== 4'b0001) begin errors++; $display("FAIL wr_g0 got grant=%0d pop=%b exp grant=0 pop=0001", bus.grant, bus.pop); end
      step; // t2
      step; // t3
      checks++; if (bus.push !== 4'b0001 || bus.data_out !== 12'h1AA) begin errors++; $display("FAIL wr_1aa got push=%b data=%h exp push=0001 data=1AA", bus.push, bus.data_out); end
      step; // t4: P1,P2 empty -> P3
      checks++; if (bus.grant !== 2'd3 || bus.pop !== 4'b1000) begin errors++; $display("FAIL wr_g3 got grant=%0d pop=%b exp grant=3 pop=1000", bus.grant, bus.pop); end
      load(0, 12'h5A5); // empty now 4'b0110 while serving P3
      step; // t5
      step; // t6
      step; // t7
      checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'd3) begin errors++; $display("FAIL wr_idle3 got busy=%b grant=%0d exp busy=0 grant=3", bus.busy, bus.grant); end
      step; // t8: wrap 3 -> 0
      checks++; if (bus.grant !== 2'd0 || bus.pop !== 4'b0001) begin errors++; $display("FAIL wr_wrap0 got grant=%0d pop=%b exp grant=0 pop=0001", bus.grant, bus.pop); end
      step; // t9
      step; // t10
      checks++; if (bus.busy !== 1'b0 || bus.grant !== 2'd0) begin errors++; $display("FAIL wr_idle0 got busy=%b grant=%0d exp busy=0 grant=0", bus.busy, bus.grant); end
      load(3, 12'hDDD);
      step; // t11
      checks++; if (bus.grant !== 2'd3 || bus.pop !== 4'b1000) begin errors++; $display("FAIL wr_g3b got grant=%0d pop=%b exp grant=3 pop=1000", bus.grant, bus.pop); end
      step; // t12
      step; // t13
      load(3, 12'hBBB); // only P3 non-empty with grant=3
      step; // t14
      checks++; if (bus.grant !== 2'd3 || bus.busy !== 1'b1 || bus.pop !== 4'b1000) begin errors++; $display("FAIL wr_regrant got grant=%0d busy=%b pop=%b exp grant=3 busy=1 pop=1000", bus.grant, bus.busy, bus.pop); end
      step; step; step;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_switch;
      test_stall;
      test_reset_mid;
      test_wrap;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
